uart_rx_frame_ctrl: RTL and testbench
=====================================

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, number of data bits per frame, LSB first.
REQ-002 SHALL provide port CLK_STOP_CHECK  input  1  oversampling clock (Prescale ticks per bit).
REQ-003 SHALL provide port RST_STOP_CHECK  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port RX_IN  input  1  serial line, already synchronized, idle high.
REQ-005 SHALL provide port PAR_EN  input  1  parity bit present when 1.
REQ-006 SHALL provide port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL provide port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-008 SHALL provide port stp_err_in  input  1  stop error returned by the downstream stop-check stage.
REQ-009 SHALL provide port sampled_bit  output  1  majority-voted bit value, feeds the stop-check stage.
REQ-010 SHALL provide port stp_chk_en  output  1  one-cycle strobe telling the stop-check stage to evaluate sampled_bit.
REQ-011 SHALL provide port P_DATA  output  DATA_WIDTH  last accepted data word.
REQ-012 SHALL provide port data_valid  output  1  one-cycle strobe, P_DATA updated this cycle.
REQ-013 SHALL provide port par_err  output  1  parity mismatch flag for the current or last frame.
REQ-014 SHALL provide port strt_glitch  output  1  one-cycle strobe, false start bit rejected.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-016 SHALL latch Prescale at start detection; Prescale changes mid-frame are ignored; values other than 16 or 32 are treated as 8.
REQ-017 SHALL keep edge counter edge_cnt, 0..P-1 per bit (P = latched prescale); detection cycle is edge 0, edge_cnt = 1 on the next cycle; wraps to 0 after P-1 and bit_cnt increments.
REQ-018 SHALL sample RX_IN at edges P/2-1, P/2, P/2+1 and register the 2-of-3 majority into sampled_bit at edge P/2+2; sampled_bit holds until the next update.
REQ-019 IDLE: RX_IN = 0 -> START, par_err cleared; otherwise remain in IDLE.
REQ-020 START: at edge P-1, sampled_bit = 1 -> strt_glitch = 1 for one cycle and return to IDLE; otherwise -> DATA with bit_cnt = 0.
REQ-021 DATA: at edge P-1 of each bit, shift sampled_bit into shift register LSB first; after DATA_WIDTH bits -> PARITY if PAR_EN = 1, else -> STOP.
REQ-022 PARITY: at edge P-1, par_err <= (XOR of data bits XOR PAR_TYP) != sampled_bit; -> STOP.
REQ-023 STOP: stp_chk_en = 1 for exactly one cycle, the cycle after sampled_bit updates (edge P/2+3); at edge P-1 -> DONE.
REQ-024 DONE, lasting one cycle: if par_err = 0 and stp_err_in = 0, load P_DATA from the shift register and pulse data_valid; otherwise P_DATA holds and data_valid stays 0.
REQ-025 DONE exit: RX_IN = 0 -> START directly (back-to-back frame, edge_cnt = 1 next cycle, par_err cleared); else -> IDLE.
REQ-026 stp_chk_en, data_valid and strt_glitch SHALL never be high outside the states named above; at most one of them is high in any cycle.
REQ-027 par_err SHALL hold its value until the next start detection.
REQ-028 PAR_EN and PAR_TYP SHALL be latched at start detection.

Reset
REQ-029 RST_STOP_CHECK low SHALL immediately force state IDLE, edge_cnt = 0, bit_cnt = 0, shift register = 0, P_DATA = 0, sampled_bit = 0, stp_chk_en = 0, data_valid = 0, par_err = 0, strt_glitch = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no data_valid; after release the block waits for a fresh falling edge in IDLE.

Verification
REQ-031 Prescale = 8, PAR_EN = 0, frame 0xA5 with stop = 1, stp_err_in = 0 -> stp_chk_en one cycle in STOP; data_valid one cycle; P_DATA = 0xA5.
REQ-032 Prescale = 16, PAR_EN = 1, PAR_TYP = 0, data 0x3C, parity bit 1 (wrong) -> par_err = 1, no data_valid, P_DATA unchanged.
REQ-033 Prescale = 32, RX_IN low for 4 cycles then high -> strt_glitch one cycle, return to IDLE, no stp_chk_en.
REQ-034 Prescale = 8, stop bit 0, checker returns stp_err_in = 1 -> no data_valid, P_DATA unchanged.
REQ-035 Two back-to-back frames 0x55 then 0xF0, no idle gap -> two data_valid pulses 10*P cycles apart, P_DATA = 0x55 then 0xF0.
REQ-036 Reset pulsed during DATA bit 3 -> all outputs 0; next valid frame 0x81 -> P_DATA = 0x81.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampled UART receive framer with 2-of-3 majority vote, optional parity and an external stop-bit check
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK_STOP_CHECK,
    input  logic                  RST_STOP_CHECK,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    input  logic                  stp_err_in,
    output logic                  sampled_bit,
    output logic                  stp_chk_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  strt_glitch
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
    state_t                  state;
    logic [5:0]              p;
    logic [5:0]              edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift;
    logic [2:0]              smp;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic [5:0]              half;
    logic                    last;
    logic                    start_det;
    assign half      = {1'b0, p[5:1]};
    assign last      = edge_cnt == p - 6'd1;
    // DONE doubles as edge 0 of a back-to-back start bit
    assign start_det = (state == IDLE || state == DONE) && !RX_IN;
    always_ff @(posedge CLK_STOP_CHECK or negedge RST_STOP_CHECK) begin
        if (!RST_STOP_CHECK) begin
            state       <= IDLE;
            p           <= 6'd0;
            edge_cnt    <= 6'd0;
            bit_cnt     <= '0;
            shift       <= '0;
            smp         <= 3'b0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            sampled_bit <= 1'b0;
            stp_chk_en  <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            stp_chk_en  <= state == STOP && edge_cnt == half + 6'd2;
            data_valid  <= 1'b0;
            strt_glitch <= 1'b0;
            edge_cnt    <= last ? 6'd0 : edge_cnt + 6'd1;
            if (edge_cnt == half - 6'd1) smp[0] <= RX_IN;
            if (edge_cnt == half)        smp[1] <= RX_IN;
            if (edge_cnt == half + 6'd1) smp[2] <= RX_IN;
            if (edge_cnt == half + 6'd2)
                sampled_bit <= (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
            if (start_det) begin
                state     <= START;
                edge_cnt  <= 6'd1;
                p         <= Prescale == 6'd16 ? 6'd16 : Prescale == 6'd32 ? 6'd32 : 6'd8;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_err   <= 1'b0;
            end else if (state == IDLE || state == DONE) begin
                state    <= IDLE;
                edge_cnt <= 6'd0;
            end else if (last) begin
                unique case (state)
                    START: begin
                        if (sampled_bit) begin
                            state       <= IDLE;
                            strt_glitch <= 1'b1;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= par_en_q ? PARITY : STOP;
                    end
                    PARITY: begin
                        par_err <= (^shift ^ par_typ_q) != sampled_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= DONE;
                        if (!par_err && !stp_err_in) begin
                            P_DATA     <= shift;
                            data_valid <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames with hand-computed expectations for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
    logic       CLK_STOP_CHECK = 1'b0;
    logic       RST_STOP_CHECK = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       stp_err_in = 1'b0;
    logic       sampled_bit;
    logic       stp_chk_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       strt_glitch;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dv_cnt, stp_cnt, gl_cnt, multi_cnt;
    int dv_cyc [0:3];
    logic [7:0] dv_dat [0:3];
    logic stp_sb;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK_STOP_CHECK(CLK_STOP_CHECK),
        .RST_STOP_CHECK(RST_STOP_CHECK),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .Prescale(Prescale),
        .stp_err_in(stp_err_in),
        .sampled_bit(sampled_bit),
        .stp_chk_en(stp_chk_en),
        .P_DATA(P_DATA),
        .data_valid(data_valid),
        .par_err(par_err),
        .strt_glitch(strt_glitch)
    );

    always #5 CLK_STOP_CHECK = ~CLK_STOP_CHECK;
    always @(posedge CLK_STOP_CHECK) cyc++;

    always @(negedge CLK_STOP_CHECK) begin
        if (data_valid) begin
            if (dv_cnt < 4) begin
                dv_cyc[dv_cnt] = cyc;
                dv_dat[dv_cnt] = P_DATA;
            end
            dv_cnt++;
        end
        if (stp_chk_en) begin
            stp_cnt++;
            stp_sb = sampled_bit;
        end
        if (strt_glitch) gl_cnt++;
        if (int'(data_valid) + int'(stp_chk_en) + int'(strt_glitch) > 1) multi_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK_STOP_CHECK);
            #1;
        end
    endtask

    task automatic clr();
        dv_cnt = 0;
        stp_cnt = 0;
        gl_cnt = 0;
        stp_sb = 1'bx;
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        tick(p);
    endtask

    task automatic send_frame(input int p, input logic [7:0] d, input logic pe, input logic pb, input logic sb);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pb, p);
        drive_bit(sb, p);
        RX_IN = 1'b1;
    endtask

    initial begin
        multi_cnt = 0;
        clr();
        tick(3);
        chk("rst_pdata", P_DATA, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_perr", par_err, 0);
        chk("rst_sbit", sampled_bit, 0);
        chk("rst_stpen", stp_chk_en, 0);
        chk("rst_glitch", strt_glitch, 0);
        RST_STOP_CHECK = 1'b1;
        tick(5);

        // P=8, no parity, 0xA5, good stop
        clr();
        Prescale = 6'd8;
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("a5_dv_cnt", dv_cnt, 1);
        chk("a5_stp_cnt", stp_cnt, 1);
        chk("a5_stp_sb", stp_sb, 1);
        chk("a5_pdata", P_DATA, 8'hA5);
        chk("a5_dv_dat", dv_dat[0], 8'hA5);
        chk("a5_perr", par_err, 0);

        // P=16, even parity, 0x3C with wrong parity bit 1
        clr();
        Prescale = 6'd16;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1);
        PAR_EN = 1'b0;
        tick(4);
        chk("par_err", par_err, 1);
        chk("par_dv_cnt", dv_cnt, 0);
        chk("par_pdata", P_DATA, 8'hA5);
        tick(50);
        chk("par_err_hold", par_err, 1);

        // P=16, odd parity, 0x3C with correct parity bit 1
        clr();
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
        send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1);
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        tick(4);
        chk("odd_perr", par_err, 0);
        chk("odd_dv_cnt", dv_cnt, 1);
        chk("odd_pdata", P_DATA, 8'h3C);

        // P=32, 4-cycle false start
        clr();
        Prescale = 6'd32;
        RX_IN = 1'b0;
        tick(4);
        RX_IN = 1'b1;
        tick(40);
        chk("gl_cnt", gl_cnt, 1);
        chk("gl_stp_cnt", stp_cnt, 0);
        chk("gl_dv_cnt", dv_cnt, 0);
        chk("gl_pdata", P_DATA, 8'h3C);

        // P=8, stop bit 0, checker reports error
        clr();
        Prescale = 6'd8;
        stp_err_in = 1'b1;
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0);
        tick(4);
        stp_err_in = 1'b0;
        chk("stp_dv_cnt", dv_cnt, 0);
        chk("stp_cnt", stp_cnt, 1);
        chk("stp_sb", stp_sb, 0);
        chk("stp_pdata", P_DATA, 8'h3C);

        // back-to-back 0x55 then 0xF0; illegal prescale 10 behaves as 8
        clr();
        Prescale = 6'd10;
        send_frame(8, 8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8, 8'hF0, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("b2b_dv_cnt", dv_cnt, 2);
        chk("b2b_dat0", dv_dat[0], 8'h55);
        chk("b2b_dat1", dv_dat[1], 8'hF0);
        chk("b2b_gap", dv_cyc[1] - dv_cyc[0], 80);
        chk("b2b_pdata", P_DATA, 8'hF0);

        // reset during data bit 3, then 0x81
        clr();
        Prescale = 6'd8;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 4);
        RST_STOP_CHECK = 1'b0;
        #1;
        chk("mrst_pdata", P_DATA, 0);
        chk("mrst_sbit", sampled_bit, 0);
        chk("mrst_perr", par_err, 0);
        chk("mrst_dv", data_valid, 0);
        chk("mrst_stpen", stp_chk_en, 0);
        chk("mrst_glitch", strt_glitch, 0);
        tick(2);
        RX_IN = 1'b1;
        RST_STOP_CHECK = 1'b1;
        tick(20);
        chk("mrst_no_dv", dv_cnt, 0);
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("post_dv_cnt", dv_cnt, 1);
        chk("post_pdata", P_DATA, 8'h81);

        chk("excl_strobes", multi_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
